// File: rtl/mult_hilo_unit.sv
// Iterative signed shift-add multiplier with architectural HI/LO registers.
// Stalls the PC while a mult runs and supplies LO to write-back on mflo.
module mult_hilo_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mult_operation,
  input  logic                  mflo_flag,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  output logic                  mult_stall,
  output logic                  mult_done,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] wb_data
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] mcand_reg;
  logic [DATA_WIDTH-1:0] mplier_reg;
  logic [PW-1:0]         acc_reg;
  logic [CW-1:0]         count_reg;
  logic                  sign_reg;
  logic [DATA_WIDTH-1:0] hi_reg;
  logic [DATA_WIDTH-1:0] lo_reg;

  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;
  logic [PW-1:0]         addend;
  logic [PW-1:0]         acc_sum;
  logic [PW-1:0]         product;
  logic                  last_step;

  // Negating the most negative value wraps to itself, which read as unsigned is its magnitude.
  assign abs_a     = srcA[DATA_WIDTH-1] ? -srcA : srcA;
  assign abs_b     = srcB[DATA_WIDTH-1] ? -srcB : srcB;
  assign addend    = mplier_reg[0] ? ({{DATA_WIDTH{1'b0}}, mcand_reg} << count_reg) : '0;
  assign acc_sum   = acc_reg + addend;
  assign product   = sign_reg ? -acc_sum : acc_sum;
  assign last_step = (count_reg == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mult_stall = 1'b0;
    mult_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        mult_stall = mult_operation;
        if (mult_operation) state_next = BUSY;
      end
      BUSY: begin
        mult_stall = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        mult_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Stall must fall the moment reset is asserted, even with a mult still decoded.
    if (!reset) mult_stall = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      sign_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mult_operation) begin
            mcand_reg  <= abs_a;
            mplier_reg <= abs_b;
            sign_reg   <= srcA[DATA_WIDTH-1] ^ srcB[DATA_WIDTH-1];
            acc_reg    <= '0;
            count_reg  <= '0;
          end
        end
        BUSY: begin
          acc_reg    <= acc_sum;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + 1'b1;
          if (last_step) begin
            hi_reg <= product[PW-1:DATA_WIDTH];
            lo_reg <= product[DATA_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out  = hi_reg;
  assign lo_out  = lo_reg;
  assign wb_data = mflo_flag ? lo_reg : '0;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Scoreboard bench: the driver queues the signed product of each issued mult,
// the monitor pops and checks HI/LO and stall window length on every done pulse.
module tb_mult_hilo_unit;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         mult_operation;
  logic         mflo_flag;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         mult_stall;
  logic         mult_done;
  logic [W-1:0] lo_out;
  logic [W-1:0] hi_out;
  logic [W-1:0] wb_data;

  mult_hilo_unit #(.DATA_WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .mult_operation (mult_operation),
    .mflo_flag      (mflo_flag),
    .srcA           (srcA),
    .srcB           (srcB),
    .mult_stall     (mult_stall),
    .mult_done      (mult_done),
    .lo_out         (lo_out),
    .hi_out         (hi_out),
    .wb_data        (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           n_issued = 0;
  int           n_done = 0;
  int           stall_run = 0;
  logic [63:0]  exp_q[$];
  logic [W-1:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one line per retired mult.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      stall_run = 0;
    end else begin
      if (mult_stall) stall_run++;
      if (mult_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hilo", {hi_out, lo_out}, e);
          check("stall_cycles", 64'(stall_run), 64'(W + 1));
          $display("mult done: hi=0x%08h lo=0x%08h expected=0x%016h stall=%0d",
                   hi_out, lo_out, e, stall_run);
        end
        stall_run = 0;
      end
    end
  end

  // Issue one mult in the current IDLE cycle and return in the IDLE cycle after DONE.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit scramble, input bit both);
    longint      sa;
    longint      sb;
    logic [63:0] e;
    bit          seen;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = 64'(sa * sb);
    srcA = a;
    srcB = b;
    mult_operation = 1'b1;
    mflo_flag = both;
    exp_q.push_back(e);
    n_issued++;
    #1;
    check("stall_at_issue", 64'(mult_stall), 64'd1);
    if (both) check("wb_old_lo", 64'(wb_data), 64'(model_lo));
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      mflo_flag = 1'b0;
      if (mult_done) seen = 1'b1;
      else if (scramble) begin
        srcA = $urandom;
        srcB = $urandom;
      end
    end
    check("done_timeout", 64'(seen), 64'd1);
    mult_operation = 1'b0;
    model_lo = e[W-1:0];
    mflo_flag = 1'b1;
    #1;
    check("wb_mflo", 64'(wb_data), 64'(model_lo));
    mflo_flag = 1'b0;
    #1;
    check("wb_no_mflo", 64'(wb_data), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic abort_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    srcA = a;
    srcB = b;
    mult_operation = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_stall", 64'(mult_stall), 64'd0);
    check("abort_done", 64'(mult_done), 64'd0);
    check("abort_hilo", {hi_out, lo_out}, 64'd0);
    mult_operation = 1'b0;
    model_lo = '0;
    $display("reset asserted mid-busy: stall=%0b done=%0b hi=0x%08h lo=0x%08h",
             mult_stall, mult_done, hi_out, lo_out);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_abort_idle_stall", 64'(mult_stall), 64'd0);
    check("post_abort_idle_done", 64'(mult_done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset = 1'b0;
    mult_operation = 1'b0;
    mflo_flag = 1'b1;
    srcA = '0;
    srcB = '0;
    #2;
    check("reset_stall", 64'(mult_stall), 64'd0);
    check("reset_done", 64'(mult_done), 64'd0);
    check("reset_hilo", {hi_out, lo_out}, 64'd0);
    check("reset_wb", 64'(wb_data), 64'd0);
    mflo_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    do_mult(32'd7, 32'd6, 1'b0, 1'b0);
    do_mult(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
    do_mult(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_mult(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    do_mult($urandom, $urandom, 1'b1, 1'b0);
    abort_mult(32'h1234_5678, 32'h9ABC_DEF1);
    do_mult(32'd2, 32'd3, 1'b0, 1'b0);
    do_mult(32'd4, 32'd5, 1'b0, 1'b0);
    do_mult(32'd0, 32'd9, 1'b0, 1'b0);
    check("final_lo", 64'(lo_out), 64'd0);
    check("final_hi", 64'(hi_out), 64'd0);
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = 32'h8000_0000;
      if (i % 4 == 2) rb = 32'($urandom_range(0, 15)) - 32'd8;
      do_mult(ra, rb, i[0], i[1]);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(n_done), 64'(n_issued));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
